// File: rtl/cod_mem_pkg.sv
// Shared definitions for the compute-result RAM and its stream reader:
// default geometry and the reader FSM state encoding.
package cod_mem_pkg;

    localparam int CM_ADDR_W = 6;
    localparam int CM_DATA_W = 32;

    typedef enum logic [1:0] {
        RSR_IDLE  = 2'd0,
        RSR_READ  = 2'd1,
        RSR_DRAIN = 2'd2,
        RSR_DONE  = 2'd3
    } rsr_state_e;

endpackage

// File: rtl/rsr_fifo2.sv
// Two-entry FIFO holding {last, data} words returned by RAM port B.
// The head entry is presented combinationally so the stream output stays stable under stall.
module rsr_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign pop_ok  = pop && (cnt != 2'd0);
    assign push_ok = push && ((cnt != 2'd2) || pop_ok);
    assign dout    = mem[rd_ptr];

    // NOTE: non-blocking (<=) for every register so all state updates see pre-edge values.
    // NOTE: storage is only two entries, so it is reset to give m_data a defined 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks RAM port B from base_addr for len words and streams them on a valid/ready port.
// Optional running checksum of popped words is built when RSR_CHECKSUM_EN is defined.
module ram_stream_reader
    import cod_mem_pkg::*;
#(
    parameter int ADDR_W = CM_ADDR_W,
    parameter int DATA_W = CM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef RSR_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

    rsr_state_e        state_q, state_d;
    logic [ADDR_W:0]   rem_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [1:0]        fifo_cnt;
    logic [DATA_W:0]   fifo_dout;
    logic [2:0]        occ;
    logic              pop;
    logic              issue;
    logic              accept;

    assign pop     = m_valid & m_ready;
    assign accept  = (state_q == RSR_IDLE) && start;
    // Occupancy the FIFO will have once the current in-flight word lands and any pop completes.
    assign occ     = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue   = (state_q == RSR_READ) && (rem_q != '0) && (occ < 3'd2);

    assign busy    = (state_q == RSR_READ) || (state_q == RSR_DRAIN);
    assign done    = (state_q == RSR_DONE);
    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = fifo_dout[DATA_W-1:0];
    assign m_last  = fifo_dout[DATA_W] & m_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RSR_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            RSR_IDLE: begin
                if (start) state_d = (len == '0) ? RSR_DONE : RSR_READ;
            end
            RSR_READ: begin
                if (issue && (rem_q == REM_ONE)) state_d = RSR_DRAIN;
            end
            RSR_DRAIN: begin
                // Leave as the final word handshakes so done follows it by one cycle.
                if (!inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop)))
                    state_d = RSR_DONE;
            end
            RSR_DONE: state_d = RSR_IDLE;
            default:  state_d = RSR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrb           <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && (rem_q == REM_ONE);
            if (accept) begin
                addrb <= base_addr;
                rem_q <= len;
            end else if (issue) begin
                addrb <= addrb + 1'b1;
                rem_q <= rem_q - 1'b1;
            end
        end
    end

    rsr_fifo2 #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   ({inflight_last_q, doutb}),
        .pop   (pop),
        .dout  (fifo_dout),
        .cnt   (fifo_cnt)
    );

`ifdef RSR_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      checksum <= '0;
        else if (accept) checksum <= '0;
        else if (pop)    checksum <= checksum + m_data;
    end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural synchronous RAM on port B.
// Build with RSR_CHECKSUM_EN defined to also check the checksum output.
module tb_ram_stream_reader;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef RSR_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] mem [64];

    int tests_run;
    int tests_failed;

    logic [DW-1:0] got_q [$];
    logic          last_q [$];
    logic [AW-1:0] alog_q [$];
    int            first_valid;
    int            last_pop_cyc;
    int            done_cyc;
    int            busy_at_1;
    logic [DW-1:0] cs_at_done;

    ram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
`ifdef RSR_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) doutb <= mem[addrb];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int b, input int l);
        base_addr = AW'(b);
        len       = (AW+1)'(l);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Runs from cycle T+1 until done, logging handshakes; mode 1 toggles m_ready 1,0,0,1,0,1.
    // inj_cyc > 0 injects a start (base 20, len 5) at that cycle, which must be ignored.
    task automatic collect(input int mode, input int inj_cyc, input int budget);
        logic          pat [6];
        logic          stalled;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        int            cyc;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        got_q.delete();
        last_q.delete();
        alog_q.delete();
        first_valid  = -1;
        last_pop_cyc = -1;
        done_cyc     = -1;
        stalled      = 1'b0;
        prev_data    = '0;
        prev_last    = 1'b0;
        cyc          = 1;
        busy_at_1    = busy;
        while (cyc <= budget) begin
            m_ready = (mode == 1) ? pat[cyc % 6] : 1'b1;
            if (inj_cyc > 0 && cyc == inj_cyc) begin
                base_addr = AW'(20);
                len       = (AW+1)'(5);
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            alog_q.push_back(addrb);
            if (m_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stalled) begin
                    check("stall_data", m_data, prev_data);
                    check("stall_last", m_last, prev_last);
                end
                if (m_ready) begin
                    got_q.push_back(m_data);
                    last_q.push_back(m_last);
                    if (m_last) last_pop_cyc = cyc;
                end
            end
            stalled   = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (done) begin
                done_cyc = cyc;
`ifdef RSR_CHECKSUM_EN
                cs_at_done = checksum;
`endif
                break;
            end
            tick();
            cyc++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_words(input string tag, input int b, input int n);
        int nlast;
        check({tag, "_count"}, got_q.size(), n);
        nlast = 0;
        for (int i = 0; i < got_q.size() && i < n; i++) begin
            check({tag, "_data"}, got_q[i], mem[(b + i) % 64]);
            if (last_q[i]) nlast++;
        end
        check({tag, "_one_last"}, nlast, 1);
        if (got_q.size() == n) check({tag, "_last_pos"}, last_q[n-1], 1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        base_addr    = '0;
        len          = '0;
        m_ready      = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = DW'(i * 3);

        repeat (2) tick();
        check("rst_addrb", addrb, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
`ifdef RSR_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: base 0, len 8, sink always ready
        start_burst(0, 8);
        collect(0, 0, 100);
        check("t1_busy", busy_at_1, 1);
        check("t1_addr_first", alog_q[0], 0);
        check("t1_first_valid", first_valid, 3);
        check("t1_last_cyc", last_pop_cyc, 10);
        check("t1_done_cyc", done_cyc, 11);
        check_words("t1", 0, 8);
        tick();
        check("t1_done_pulse", done, 0);
        tick();

        // 2: address wrap 62,63,0,1
        start_burst(62, 4);
        collect(0, 0, 100);
        check("t2_a0", alog_q[0], 62);
        check("t2_a1", alog_q[1], 63);
        check("t2_a2", alog_q[2], 0);
        check("t2_a3", alog_q[3], 1);
        check_words("t2", 62, 4);
        tick();

        // 3: backpressure pattern
        start_burst(5, 6);
        collect(1, 0, 200);
        check_words("t3", 5, 6);
        tick();

        // 4a: len 0 completes at once with no words
        start_burst(9, 0);
        collect(0, 0, 20);
        check("t4_done_cyc", done_cyc, 1);
        check("t4_no_valid", first_valid, -1);
        check("t4_no_busy", busy_at_1, 0);
        tick();

        // 4b: start while busy is ignored
        start_burst(10, 4);
        collect(0, 2, 100);
        check_words("t4b", 10, 4);
        repeat (8) begin
            tick();
            check("t4b_quiet", {busy, m_valid}, 0);
        end

        // 5: asynchronous abort during word 3 of len 10
        start_burst(0, 10);
        repeat (4) tick();
        check("t5_pre_valid", m_valid, 1);
        check("t5_pre_data", m_data, mem[2]);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_abort", {busy, done, m_valid, m_last}, 0);
        check("t5_abort_addr", addrb, 0);
        check("t5_abort_data", m_data, 0);
        tick();
        check("t5_idle", {busy, done, m_valid}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        start_burst(3, 3);
        collect(0, 0, 100);
        check("t5_done_cyc", done_cyc, 6);
        check_words("t5", 3, 3);
        tick();

        // 6: whole RAM, mem[i]=i
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        start_burst(0, 64);
        collect(0, 0, 300);
        check_words("t6", 0, 64);
`ifdef RSR_CHECKSUM_EN
        check("t6_checksum", cs_at_done, 2016);
        repeat (3) tick();
        check("t6_checksum_hold", checksum, 2016);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
